// File: rtl/voice_allocator.sv
// Polyphonic voice allocator feeding phase_bank_p.
// Note events are matched against the slot table by a serial scan. Matching
// notes retrigger, new notes take the lowest free slot, and when every slot is
// busy the oldest voice is stolen. The table is streamed one slot per clk_en.
// The scan is pipelined: each slot is registered in one clock and compared in
// the next. That costs one extra scan clock but keeps the slot read mux out of
// the compare path.
module voice_allocator #(
  parameter int NBANKS = 10,
  parameter int SLOT_W = 4,
  parameter int AGE_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_ev_valid,
  input  logic              i_ev_on,
  input  logic [6:0]        i_ev_note,
  output logic              o_ev_ready,
  input  logic              i_all_off,
  output logic [6:0]        o_midi,
  output logic [SLOT_W-1:0] o_slot,
  output logic [SLOT_W-1:0] o_voices,
  output logic              o_steal
);

  // state     | meaning
  // ST_IDLE   | waiting for an event, o_ev_ready high
  // ST_SCAN   | walking slots 0..NBANKS-1 (plus one compare-drain clock)
  // ST_COMMIT | writing the table for the latched event
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_COMMIT} state_t;

  localparam int                CNT_W    = SLOT_W + 1;
  localparam logic [SLOT_W-1:0] LAST     = SLOT_W'(NBANKS - 1);
  localparam logic [CNT_W-1:0]  SCAN_END = CNT_W'(NBANKS);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  state_t             state_q, state_d;
  logic [SLOT_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   scan_j_q, scan_j_d;
  logic               ev_on_q, ev_on_d;
  logic [6:0]         ev_note_q, ev_note_d;

  logic               vis_valid_q, vis_valid_d;
  logic [SLOT_W-1:0]  vis_idx_q, vis_idx_d;
  logic               vis_active_q, vis_active_d;
  logic [6:0]         vis_note_q, vis_note_d;
  logic [AGE_W-1:0]   vis_age_q, vis_age_d;

  logic               match_found_q, match_found_d;
  logic [SLOT_W-1:0]  match_idx_q, match_idx_d;
  logic               free_found_q, free_found_d;
  logic [SLOT_W-1:0]  free_idx_q, free_idx_d;
  logic               old_found_q, old_found_d;
  logic [SLOT_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]   old_age_q, old_age_d;

  logic [6:0]         note_q [NBANKS];
  logic [6:0]         note_d [NBANKS];
  logic [NBANKS-1:0]  active_q, active_d;
  logic [AGE_W-1:0]   age_q [NBANKS];
  logic [AGE_W-1:0]   age_d [NBANKS];

  logic [SLOT_W-1:0]  voices_q, voices_d;
  logic               steal_q, steal_d;

  logic [SLOT_W-1:0]  tgt;
  logic [SLOT_W-1:0]  act_cnt;

  // Stream outputs come straight off the table and scan pointer registers.
  always_comb begin
    o_slot     = ptr_q;
    o_midi     = active_q[ptr_q] ? note_q[ptr_q] : 7'd0;
    o_ev_ready = (state_q == ST_IDLE);
    o_voices   = voices_q;
    o_steal    = steal_q;
  end

  // Next-state logic: stream pointer, event FSM, scan fold and table commit.
  always_comb begin
    ptr_d         = ptr_q;
    state_d       = state_q;
    scan_j_d      = scan_j_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    vis_valid_d   = 1'b0;
    vis_idx_d     = vis_idx_q;
    vis_active_d  = vis_active_q;
    vis_note_d    = vis_note_q;
    vis_age_d     = vis_age_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    note_d        = note_q;
    active_d      = active_q;
    age_d         = age_q;
    voices_d      = voices_q;
    steal_d       = 1'b0;
    tgt           = '0;
    act_cnt       = '0;

    if (clk_en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + SLOT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        // Note 0 is accepted (ready is high) but never starts a scan.
        if (i_ev_valid && (i_ev_note != 7'd0)) begin
          ev_on_d       = i_ev_on;
          ev_note_d     = i_ev_note;
          scan_j_d      = '0;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          old_age_d     = '0;
          state_d       = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_j_q != SCAN_END) begin
          vis_valid_d  = 1'b1;
          vis_idx_d    = scan_j_q[SLOT_W-1:0];
          vis_active_d = active_q[scan_j_q[SLOT_W-1:0]];
          vis_note_d   = note_q[scan_j_q[SLOT_W-1:0]];
          vis_age_d    = age_q[scan_j_q[SLOT_W-1:0]];
          scan_j_d     = scan_j_q + CNT_W'(1);
        end else begin
          state_d = ST_COMMIT;
        end
        // Slots arrive in ascending order, so first-hit and strict '>' give lowest index on ties.
        if (vis_valid_q) begin
          if (!match_found_q && vis_active_q && (vis_note_q == ev_note_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = vis_idx_q;
          end
          if (!free_found_q && !vis_active_q) begin
            free_found_d = 1'b1;
            free_idx_d   = vis_idx_q;
          end
          if (vis_active_q && (!old_found_q || (vis_age_q > old_age_q))) begin
            old_found_d = 1'b1;
            old_idx_d   = vis_idx_q;
            old_age_d   = vis_age_q;
          end
        end
      end
      ST_COMMIT: begin
        if (ev_on_q) begin
          if (match_found_q) begin
            tgt = match_idx_q;
          end else if (free_found_q) begin
            tgt = free_idx_q;
          end else begin
            tgt     = old_idx_q;
            steal_d = 1'b1;
          end
          for (int i = 0; i < NBANKS; i++) begin
            if (active_q[i] && (SLOT_W'(i) != tgt) && (age_q[i] != AGE_MAX)) begin
              age_d[i] = age_q[i] + AGE_W'(1);
            end
          end
          // A retrigger rewrites the same note, so the phase bank keeps its phase.
          note_d[tgt]   = ev_note_q;
          active_d[tgt] = 1'b1;
          age_d[tgt]    = '0;
        end else if (match_found_q) begin
          active_d[match_idx_q] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < NBANKS; i++) begin
      act_cnt = act_cnt + SLOT_W'(active_d[i]);
    end
    if (state_q == ST_COMMIT) begin
      voices_d = act_cnt;
    end

    // Panic overrides everything, including an event offered this same clock.
    if (i_all_off) begin
      state_d  = ST_IDLE;
      active_d = '0;
      age_d    = '{default: '0};
      voices_d = '0;
      steal_d  = 1'b0;
    end
  end

  // State registers; reset parks the pointer on the last slot like phase_bank_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ptr_q         <= LAST;
      scan_j_q      <= '0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      vis_valid_q   <= 1'b0;
      vis_idx_q     <= '0;
      vis_active_q  <= 1'b0;
      vis_note_q    <= '0;
      vis_age_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      note_q        <= '{default: '0};
      active_q      <= '0;
      age_q         <= '{default: '0};
      voices_q      <= '0;
      steal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      scan_j_q      <= scan_j_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      vis_valid_q   <= vis_valid_d;
      vis_idx_q     <= vis_idx_d;
      vis_active_q  <= vis_active_d;
      vis_note_q    <= vis_note_d;
      vis_age_q     <= vis_age_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      note_q        <= note_d;
      active_q      <= active_d;
      age_q         <= age_d;
      voices_q      <= voices_d;
      steal_q       <= steal_d;
    end
  end

endmodule
